// File: rtl/and_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : and_share_arbiter_pkg
// Description : State encoding and default sizing for the shared-resource
//               round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package and_share_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int c_N_DEFAULT       = 16;
  localparam int c_TIMEOUT_DEFAULT = 15;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int c_CNT_W           = 8;

endpackage
`default_nettype wire

// File: rtl/and_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request bit at or
//               after ptr, wrapping through N-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] sel,
  output logic          any_req
);

  localparam logic [IW:0] c_N = (IW + 1)'(N);

  logic [IW:0] w_idx;

  // Scan from the farthest rotated position down to ptr so the nearest wins.
  always_comb begin
    sel     = '0;
    any_req = |req;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = {1'b0, ptr} + (IW + 1)'(k);
      if (w_idx >= c_N) begin
        w_idx = w_idx - c_N;
      end
      if (req[w_idx[IW-1:0]]) begin
        sel = w_idx[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/and_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : and_share_arbiter
// Description : Round-robin sequencer sharing one multi-cycle resource among
//               N requesters, with start pulse, ack and timeout error.
// Revision    : 1.0 - initial release
// ============================================================================
module and_share_arbiter
  import and_share_arbiter_pkg::*;
#(
  parameter int N       = c_N_DEFAULT,
  parameter int IW      = $clog2(N),
  parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
  input  logic          C,
  input  logic          R,
  input  logic [N-1:0]  req,
  input  logic          res_done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          res_start,
  output logic [N-1:0]  ack,
  output logic          err,
  output logic          busy
);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT);
  localparam logic [IW-1:0]      c_ID_LAST  = IW'(N - 1);
  localparam logic [N-1:0]       c_ONE      = N'(1);

  state_t             r_state;
  logic [IW-1:0]      r_ptr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [IW-1:0]      w_sel;
  logic               w_any;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (r_ptr),
    .sel     (w_sel),
    .any_req (w_any)
  );

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      res_start <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_start <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            gnt       <= c_ONE << w_sel;
            gnt_id    <= w_sel;
            res_start <= 1'b1;
            busy      <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A done arriving on the timeout cycle still counts as success.
          if (res_done || (r_cnt == c_CNT_LAST)) begin
            ack     <= gnt;
            err     <= ~res_done;
            gnt     <= '0;
            busy    <= 1'b0;
            r_ptr   <= (gnt_id == c_ID_LAST) ? '0 : gnt_id + 1'b1;
            r_state <= ST_IDLE;
          end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_and_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_and_share_arbiter
// Description : Scoreboard bench for and_share_arbiter with a delay-programmable
//               resource responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_and_share_arbiter;

  localparam int N       = 16;
  localparam int IW      = 4;
  localparam int TIMEOUT = 15;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [N-1:0]  req      = '0;
  logic          res_done = 1'b0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          res_start;
  logic [N-1:0]  ack;
  logic          err;
  logic          busy;

  always #5 clk = ~clk;

  and_share_arbiter #(
    .N       (N),
    .IW      (IW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .C         (clk),
    .R         (rst),
    .req       (req),
    .res_done  (res_done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .res_start (res_start),
    .ack       (ack),
    .err       (err),
    .busy      (busy)
  );

  typedef struct {int id; int gap;} gnt_exp_t;
  typedef struct {int mask; int err; int lat;} ack_exp_t;

  gnt_exp_t gnt_q[$];
  ack_exp_t ack_q[$];
  gnt_exp_t ge;
  ack_exp_t ae;

  int errors     = 0;
  int checks     = 0;
  int ncyc       = 0;
  int n_gnt      = 0;
  int gnt_cyc    = 0;
  int ack_cyc    = 0;
  int done_delay = -1;
  int resp_cnt   = -1;
  bit idle_done  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic exp_gnt(input int id, input int gap);
    gnt_exp_t e;
    e.id  = id;
    e.gap = gap;
    gnt_q.push_back(e);
  endtask

  task automatic exp_ack(input int mask, input int e_err, input int lat);
    ack_exp_t e;
    e.mask = mask;
    e.err  = e_err;
    e.lat  = lat;
    ack_q.push_back(e);
  endtask

  // Resource model: res_done pulses done_delay cycles after the res_start cycle.
  initial forever begin
    @(negedge clk);
    res_done = 1'b0;
    if (idle_done) res_done = 1'b1;
    if (res_start && done_delay >= 0) resp_cnt = done_delay;
    if (resp_cnt == 0) res_done = 1'b1;
    if (resp_cnt >= 0) resp_cnt--;
  end

  // Monitor: invariants every cycle, scoreboard pops on grant and ack.
  initial forever begin
    @(negedge clk);
    ncyc++;
    if (!rst) begin
      chk("busy_vs_gnt", busy, gnt != '0);
      chk("gnt_onehot0", $onehot0(gnt), 1);
      chk("ack_onehot0", $onehot0(ack), 1);
      if (ack == '0) chk("err_without_ack", err, 0);
      if (res_start) begin
        n_gnt++;
        gnt_cyc = ncyc;
        chk("gnt_expected", gnt_q.size() != 0, 1);
        if (gnt_q.size() != 0) begin
          ge = gnt_q.pop_front();
          chk("gnt_id", gnt_id, ge.id);
          chk("gnt_vec", gnt, 1 << ge.id);
          if (ge.gap >= 0) chk("ack_to_gnt_gap", ncyc - ack_cyc, ge.gap);
        end
      end
      if (ack != '0) begin
        ack_cyc = ncyc;
        chk("ack_expected", ack_q.size() != 0, 1);
        if (ack_q.size() != 0) begin
          ae = ack_q.pop_front();
          chk("ack_vec", ack, ae.mask);
          chk("err", err, ae.err);
          chk("ack_latency", ncyc - gnt_cyc, ae.lat);
          chk("busy_at_ack", busy, 0);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnts(input int target);
    int t = 0;
    while (n_gnt < target && t < 400) begin
      step();
      t++;
    end
    chk("wait_gnt_bound", n_gnt >= target, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || ack_q.size() != 0) && t < 200) begin
      step();
      t++;
    end
    chk("wait_idle_bound", !busy && ack_q.size() == 0, 1);
  endtask

  task automatic run(input logic [N-1:0] r, input int n, input int dly);
    int base = n_gnt;
    done_delay = dly;
    req = r;
    wait_gnts(base + n);
    req = '0;
    wait_idle();
  endtask

  initial begin
    int base;
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_start", res_start, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Single request, done two cycles after start.
    exp_gnt(2, -1);
    exp_ack(32'h0004, 0, 3);
    done_delay = 2;
    req = 16'h0004;
    step();
    chk("t1_gnt", gnt, 16'h0004);
    chk("t1_gnt_id", gnt_id, 2);
    chk("t1_start", res_start, 1);
    req = '0;
    step();
    chk("t1_start_once", res_start, 0);
    wait_idle();

    // Pointer now 3: picks 3 over 0 and 2, then 15 over 0 (pointer 4).
    exp_gnt(3, -1);
    exp_ack(32'h0008, 0, 1);
    run(16'h000D, 1, 0);
    exp_gnt(15, -1);
    exp_ack(32'h8000, 0, 1);
    run(16'h8001, 1, 0);

    // Fairness from pointer 0 with immediate done.
    for (int i = 0; i < 17; i++) begin
      exp_gnt(i % 16, (i == 0) ? -1 : 1);
      exp_ack(1 << (i % 16), 0, 1);
    end
    run(16'hFFFF, 17, 0);

    // Move pointer to 14, then wrap and skip 14/15.
    exp_gnt(13, -1);
    exp_ack(32'h2000, 0, 1);
    run(16'h2000, 1, 0);
    exp_gnt(0, -1);
    exp_ack(32'h0001, 0, 1);
    exp_gnt(1, 1);
    exp_ack(32'h0002, 0, 1);
    exp_gnt(0, 1);
    exp_ack(32'h0001, 0, 1);
    run(16'h0003, 3, 0);

    // Timeout with no done.
    exp_gnt(8, -1);
    exp_ack(32'h0100, 1, TIMEOUT);
    run(16'h0100, 1, -1);

    // Done on the timeout cycle wins.
    exp_gnt(8, -1);
    exp_ack(32'h0100, 0, TIMEOUT);
    run(16'h0100, 1, TIMEOUT - 1);

    // Request dropped right after grant still acks.
    exp_gnt(6, -1);
    exp_ack(32'h0040, 0, 6);
    run(16'h0040, 1, 5);

    // res_done while idle is ignored.
    done_delay = -1;
    idle_done = 1'b1;
    step();
    idle_done = 1'b0;
    step();
    step();
    chk("idle_done_busy", busy, 0);
    chk("idle_done_gnt", gnt, 0);
    chk("idle_done_ack", ack, 0);
    chk("idle_done_start", res_start, 0);

    // Asynchronous reset mid-WAIT.
    exp_gnt(4, -1);
    done_delay = -1;
    base = n_gnt;
    req = 16'h0010;
    wait_gnts(base + 1);
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_gnt_id", gnt_id, 0);
    chk("arst_busy", busy, 0);
    chk("arst_start", res_start, 0);
    chk("arst_ack", ack, 0);
    chk("arst_err", err, 0);
    req = '0;
    step();
    rst = 1'b0;
    step();

    // Pointer back at 0 picks 0 rather than 8.
    exp_gnt(0, -1);
    exp_ack(32'h0001, 0, 1);
    run(16'h0101, 1, 0);

    step();
    chk("gnt_q_drained", gnt_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
